main_memory_responder: RTL and testbench
========================================

MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: access cycles before data transfer; legal range 1..255.
REQ-002 SHALL have parameter MEM_WORDS_LOG2, default 12: log2 of the 32-bit word storage depth.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high together with req_valid.
REQ-007 SHALL have port req_write  input  1  1 = single-word write, 0 = 512-bit block read.
REQ-008 SHALL have port req_addr  input  32  byte address; [5:2] word offset, [MEM_WORDS_LOG2+1:6] block number, other bits ignored (aliased).
REQ-009 SHALL have port req_wdata  input  32  write word.
REQ-010 SHALL have port resp_valid  output  1  response available.
REQ-011 SHALL have port resp_ready  input  1  response consumed when high together with resp_valid.
REQ-012 SHALL have port resp_data  output  512  block line; word k at bits [32k+31:32k].

Function
REQ-013 SHALL implement FSM IDLE, WAIT, BURST, WRITE, DONE; req_ready = 1 only in IDLE.
REQ-014 SHALL capture req_addr, req_write and req_wdata on the accepting edge (IDLE and req_valid) and move to WAIT; later request-input changes SHALL have no effect.
REQ-015 SHALL remain in WAIT for exactly LATENCY cycles using a down-counter loaded with LATENCY-1, then go to BURST for reads or WRITE for writes.
REQ-016 SHALL in BURST read one word per cycle, mem[{block, off}] into resp_data word off, for 16 cycles, with a 4-bit off wrapping 15->0, then go to DONE.
REQ-017 SHALL in WRITE store captured wdata at mem[{block, word offset}] in one cycle, then go to DONE; resp_data unchanged for writes.
REQ-018 SHALL hold resp_valid = 1 and resp_data stable in DONE until resp_ready = 1, then return to IDLE on that edge.
REQ-019 SHALL make resp_valid first high LATENCY+16 edges after acceptance for reads and LATENCY+1 edges for writes.
REQ-020 SHALL not accept a new request in the same cycle as a DONE handshake; back-to-back throughput is one request per (latency + 1 IDLE cycle).
REQ-021 SHALL drive resp_valid and req_ready from registered state only, with no combinational path from req_valid or resp_ready.

Reset
REQ-022 SHALL on rst_n low force state IDLE, req_ready = 1 after release, resp_valid = 0, resp_data = 0, counters = 0.
REQ-023 SHALL abort any in-flight request on reset without modifying storage; a WRITE aborted before its WRITE cycle SHALL leave memory unchanged.
REQ-024 SHALL NOT reset the storage array; contents after power-up are undefined until written.

Configuration
REQ-025 SHALL, when CRITICAL_WORD_FIRST_EN is defined, start the BURST offset at the captured word offset and wrap modulo 16, so the requested word is fetched first; resp_data content and timing are unchanged.
REQ-026 SHALL, when CRITICAL_WORD_FIRST_EN is undefined, start the BURST offset at 0.

Verification
REQ-027 SHALL cover reset mid-BURST: assert rst_n low, then check resp_valid = 0 and req_ready = 1 after release, with storage intact.
REQ-028 SHALL cover write-then-read: write 0xDEADBEEF to 0x0000_1234, then read block 0x0000_1200; expect word 13 = 0xDEADBEEF, write resp at +5 edges and read resp at +20 edges (LATENCY = 4).
REQ-029 SHALL cover backpressure: hold resp_ready = 0 for 10 cycles in DONE; resp_valid and resp_data stay stable and a req_valid pulse is not accepted.
REQ-030 SHALL cover aliasing: write 0x11111111 to 0x0000_4000 (MEM_WORDS_LOG2 = 12); a read of 0x0000_0000 returns word 0 = 0x11111111.
REQ-031 SHALL cover CRITICAL_WORD_FIRST_EN: read 0x3C; the first BURST cycle reads offset 15, offsets wrap to 0 and the final line is identical to the non-macro build.
REQ-032 SHALL cover LATENCY = 1: write resp_valid at +2 edges and read resp_valid at +17 edges.

Source files
------------

// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - block-read / word-write main memory responder with fixed access latency
// Optional feature macro: CRITICAL_WORD_FIRST_EN (burst starts at the requested word offset)
module main_memory_responder #(
   parameter int LATENCY        = 4,
   parameter int MEM_WORDS_LOG2 = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_write,
   input  logic [31:0]  req_addr,
   input  logic [31:0]  req_wdata,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [511:0] resp_data
);

   localparam int         BLK_W  = MEM_WORDS_LOG2 - 4;
   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_BURST = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [7:0]         wait_cnt;
   logic [3:0]         beat_cnt;
   logic [3:0]         off;
   logic [BLK_W-1:0]   blk;
   logic [3:0]         woff;
   logic               wr;
   logic [31:0]        wdata;
   logic [3:0]         burst_start;

   // Word storage; deliberately not reset so its contents survive rst_n.
   logic [31:0] mem [0:(1 << MEM_WORDS_LOG2) - 1];

   // Address bits above the storage depth and the byte lane bits are aliased away.
   logic unused_addr;
   assign unused_addr = ^{req_addr[31:MEM_WORDS_LOG2+2], req_addr[1:0]};

`ifdef CRITICAL_WORD_FIRST_EN
   assign burst_start = req_addr[5:2];
`else
   assign burst_start = 4'd0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: latency wait, then 16-beat burst or single-cycle write.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req_valid) state_nxt = S_WAIT;
         S_WAIT:  if (wait_cnt == 8'd0) state_nxt = wr ? S_WRITE : S_BURST;
         S_BURST: if (beat_cnt == 4'd15) state_nxt = S_DONE;
         S_WRITE: state_nxt = S_DONE;
         S_DONE:  if (resp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decode registered state only.
   always_comb begin
      req_ready  = (state == S_IDLE);
      resp_valid = (state == S_DONE);
   end

   // Request capture, latency/burst counters and response line assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= 8'd0;
         beat_cnt  <= 4'd0;
         off       <= 4'd0;
         blk       <= '0;
         woff      <= 4'd0;
         wr        <= 1'b0;
         wdata     <= 32'd0;
         resp_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  blk      <= req_addr[MEM_WORDS_LOG2+1:6];
                  woff     <= req_addr[5:2];
                  wr       <= req_write;
                  wdata    <= req_wdata;
                  wait_cnt <= LAT_M1;
                  beat_cnt <= 4'd0;
                  off      <= burst_start;
               end
            end
            S_WAIT: begin
               if (wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
            end
            S_BURST: begin
               resp_data[{off, 5'b00000} +: 32] <= mem[{blk, off}];
               off      <= off + 4'd1;
               beat_cnt <= beat_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Storage write; reset forces IDLE asynchronously so an aborted write never lands.
   always_ff @(posedge clk) begin
      if (state == S_WRITE) mem[{blk, woff}] <= wdata;
   end

endmodule

// File: tb/tb_main_memory_responder.sv
// tb/tb_main_memory_responder.sv - directed self-checking bench for main_memory_responder
module tb_main_memory_responder;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_write = 1'b0;
   logic [31:0]  req_addr = 32'd0;
   logic [31:0]  req_wdata = 32'd0;
   logic         resp_valid;
   logic         resp_ready = 1'b0;
   logic [511:0] resp_data;

   logic         l1_req_valid = 1'b0;
   logic         l1_req_ready;
   logic         l1_req_write = 1'b0;
   logic [31:0]  l1_req_addr = 32'd0;
   logic [31:0]  l1_req_wdata = 32'd0;
   logic         l1_resp_valid;
   logic         l1_resp_ready = 1'b0;
   logic [511:0] l1_resp_data;

   int total = 0;
   int bad = 0;
   logic [511:0] exp_line;

   always #5 clk = ~clk;

   main_memory_responder #(.LATENCY(4), .MEM_WORDS_LOG2(12)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
   );

   main_memory_responder #(.LATENCY(1), .MEM_WORDS_LOG2(12)) u_dut_lat1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
      .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
      .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready), .resp_data(l1_resp_data)
   );

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output int lat);
      req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
      lat = 0;
      while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic consume();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic issue_l1(input logic w, input logic [31:0] a, input logic [31:0] d, output int lat);
      l1_req_write = w; l1_req_addr = a; l1_req_wdata = d; l1_req_valid = 1'b1;
      @(posedge clk); #1;
      l1_req_valid = 1'b0; l1_req_addr = 32'hFFFF_FFFF;
      lat = 0;
      while (!l1_resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      l1_resp_ready = 1'b1;
      @(posedge clk); #1;
      l1_resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid_rel got=%b exp=0", resp_valid); end
      total++; if (resp_data !== 512'd0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
   endtask

   task automatic test_write_read();
      int lat;
      logic [511:0] prev;
      prev = resp_data;
      issue(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, lat);
      total++; if (lat != 5) begin bad++; $display("FAIL write_latency got=%0d exp=5", lat); end
      total++; if (resp_data !== prev) begin bad++; $display("FAIL write_resp_data_changed got=%h exp=%h", resp_data, prev); end
      consume();
      issue(1'b0, 32'h0000_1200, 32'd0, lat);
      total++; if (lat != 20) begin bad++; $display("FAIL read_latency got=%0d exp=20", lat); end
      total++; if (resp_data[13*32 +: 32] !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL read_word13 got=%h exp=deadbeef", resp_data[13*32 +: 32]); end
      consume();
   endtask

   task automatic test_aliasing();
      int lat;
      issue(1'b1, 32'h0000_4000, 32'h1111_1111, lat);
      consume();
      issue(1'b0, 32'h0000_0000, 32'd0, lat);
      total++; if (resp_data[31:0] !== 32'h1111_1111) begin
         bad++; $display("FAIL alias_word0 got=%h exp=11111111", resp_data[31:0]); end
      consume();
   endtask

   task automatic test_line_fill();
      int lat;
      for (int k = 0; k < 16; k++) begin
         issue(1'b1, 32'(k * 4), 32'hC0DE_0000 + 32'(k), lat);
         consume();
         exp_line[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
      end
      issue(1'b1, 32'h0000_0040, 32'h5555_0000, lat); consume();
      issue(1'b1, 32'h0000_007C, 32'h5555_000F, lat); consume();
      issue(1'b0, 32'h0000_0000, 32'd0, lat);
      total++; if (resp_data !== exp_line) begin bad++; $display("FAIL line_fill got=%h exp=%h", resp_data, exp_line); end
      consume();
   endtask

   task automatic test_critical_word_first();
      int lat;
      issue(1'b0, 32'h0000_0040, 32'd0, lat);
      total++; if (resp_data[31:0] !== 32'h5555_0000 || resp_data[15*32 +: 32] !== 32'h5555_000F) begin
         bad++; $display("FAIL cwf_preload got0=%h got15=%h exp=55550000/5555000f", resp_data[31:0], resp_data[15*32 +: 32]); end
      consume();
      req_write = 1'b0; req_addr = 32'h0000_003C; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
`ifdef CRITICAL_WORD_FIRST_EN
      total++; if (resp_data[15*32 +: 32] !== 32'hC0DE_000F || resp_data[31:0] !== 32'h5555_0000) begin
         bad++; $display("FAIL cwf_first_beat got15=%h got0=%h exp=c0de000f/55550000", resp_data[15*32 +: 32], resp_data[31:0]); end
`else
      total++; if (resp_data[31:0] !== 32'hC0DE_0000 || resp_data[15*32 +: 32] !== 32'h5555_000F) begin
         bad++; $display("FAIL cwf_first_beat got0=%h got15=%h exp=c0de0000/5555000f", resp_data[31:0], resp_data[15*32 +: 32]); end
`endif
      lat = 5;
      while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      total++; if (lat != 20) begin bad++; $display("FAIL cwf_latency got=%0d exp=20", lat); end
      total++; if (resp_data !== exp_line) begin bad++; $display("FAIL cwf_line got=%h exp=%h", resp_data, exp_line); end
      consume();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [511:0] snap;
      issue(1'b0, 32'h0000_0000, 32'd0, lat);
      snap = resp_data;
      for (int i = 0; i < 10; i++) begin
         req_valid = (i == 3);
         req_write = 1'b1; req_addr = 32'h0000_0000; req_wdata = 32'hFFFF_0000;
         @(posedge clk); #1;
         req_valid = 1'b0;
         total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, resp_valid); end
         total++; if (resp_data !== snap) begin bad++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, resp_data, snap); end
         total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", i, req_ready); end
      end
      consume();
      repeat (2) @(posedge clk);
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_not_accepted got=%b exp=1", req_ready); end
      issue(1'b0, 32'h0000_0000, 32'd0, lat);
      total++; if (resp_data[31:0] !== 32'hC0DE_0000) begin bad++; $display("FAIL bp_no_write got=%h exp=c0de0000", resp_data[31:0]); end
      consume();
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(1'b0, 32'h0000_1200, 32'd0, lat);
      resp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0000;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         bad++; $display("FAIL b2b_handshake_edge req_ready=%b resp_valid=%b exp=1/0", req_ready, resp_valid); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b exp=0", req_ready); end
      lat = 0;
      while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      total++; if (lat != 20) begin bad++; $display("FAIL b2b_latency got=%0d exp=20", lat); end
      total++; if (resp_data !== exp_line) begin bad++; $display("FAIL b2b_line got=%h exp=%h", resp_data, exp_line); end
      consume();
   endtask

   task automatic test_reset_mid_burst();
      int lat;
      req_write = 1'b0; req_addr = 32'h0000_1200; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++; if (resp_valid !== 1'b0 || resp_data !== 512'd0) begin
         bad++; $display("FAIL rmb_in_reset resp_valid=%b data_nonzero=%b exp=0/0", resp_valid, |resp_data); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         bad++; $display("FAIL rmb_release req_ready=%b resp_valid=%b exp=1/0", req_ready, resp_valid); end
      issue(1'b0, 32'h0000_0000, 32'd0, lat);
      total++; if (resp_data !== exp_line) begin bad++; $display("FAIL rmb_storage got=%h exp=%h", resp_data, exp_line); end
      consume();
   endtask

   task automatic test_write_abort();
      int lat;
      req_write = 1'b1; req_addr = 32'h0000_0008; req_wdata = 32'hBAD0_BAD0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(1'b0, 32'h0000_0000, 32'd0, lat);
      total++; if (resp_data[2*32 +: 32] !== 32'hC0DE_0002) begin
         bad++; $display("FAIL abort_word2 got=%h exp=c0de0002", resp_data[2*32 +: 32]); end
      consume();
   endtask

   task automatic test_latency1();
      int lat;
      issue_l1(1'b1, 32'h0000_0010, 32'h7777_0004, lat);
      total++; if (lat != 2) begin bad++; $display("FAIL lat1_write got=%0d exp=2", lat); end
      l1_req_write = 1'b0; l1_req_addr = 32'h0000_0000; l1_req_valid = 1'b1;
      @(posedge clk); #1;
      l1_req_valid = 1'b0;
      lat = 0;
      while (!l1_resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      total++; if (lat != 17) begin bad++; $display("FAIL lat1_read got=%0d exp=17", lat); end
      total++; if (l1_resp_data[4*32 +: 32] !== 32'h7777_0004) begin
         bad++; $display("FAIL lat1_word4 got=%h exp=77770004", l1_resp_data[4*32 +: 32]); end
      l1_resp_ready = 1'b1;
      @(posedge clk); #1;
      l1_resp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_aliasing();
      test_line_fill();
      test_critical_word_first();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_burst();
      test_write_abort();
      test_latency1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
